// File: rtl/single_port_ram_be_if.sv
// single_port_ram_be_if: request/response bundle between a bus master and the byte-enable RAM
interface single_port_ram_be_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   logic                  cs;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [BE_WIDTH-1:0]   be;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  ready;
   logic                  err;
   modport master (output cs, we, addr, wdata, be, input rdata, rvalid, ready, err);
   modport slave (input cs, we, addr, wdata, be, output rdata, rvalid, ready, err);
endinterface

// File: rtl/single_port_ram_be.sv
// single_port_ram_be: single-port RAM with byte enables, power-up clear sweep and range error;
// define RAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1)
module single_port_ram_be #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   single_port_ram_be_if.slave bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   typedef enum logic {INIT, RUN} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  accept, in_range, last_word;
   logic                  rvalid_q, err_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   assign accept    = bus.cs && state_q == RUN;
   assign in_range  = 32'(bus.addr) < 32'(DEPTH);
   assign last_word = init_cnt == ADDR_WIDTH'(DEPTH - 1);
   assign bus.ready = state_q == RUN;
   // state register and clear-sweep counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= INIT;
         init_cnt <= '0;
      end else begin
         state_q  <= state_d;
         init_cnt <= init_cnt_d;
      end
   end
   // sweep advances one word per cycle and hands over to RUN after the last word
   always_comb begin
      state_d    = (state_q == INIT && last_word) ? RUN : state_q;
      init_cnt_d = (state_q == INIT) ? init_cnt + 1'b1 : init_cnt;
   end
   // sweep clears one word per cycle; accepted in-range writes merge only the enabled lanes
   always_ff @(posedge clk) begin
      if (rst_n && state_q == INIT)
         mem[init_cnt] <= '0;
      else if (rst_n && accept && bus.we && in_range)
         for (int i = 0; i < BE_WIDTH; i++)
            if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
   end
   // first response stage: out-of-range reads return zero, rdata holds between reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= accept && !bus.we;
         err_q    <= accept && !in_range;
         if (accept && !bus.we) rdata_q <= in_range ? mem[bus.addr] : '0;
      end
   end
`ifdef RAM_OUT_REG_EN
   logic                  rvalid_r, err_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   // output stage delays the whole response (rvalid, rdata, err) by one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_r <= 1'b0;
         err_r    <= 1'b0;
         rdata_r  <= '0;
      end else begin
         rvalid_r <= rvalid_q;
         err_r    <= err_q;
         rdata_r  <= rdata_q;
      end
   end
   assign bus.rvalid = rvalid_r;
   assign bus.err    = err_r;
   assign bus.rdata  = rdata_r;
`else
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;
`endif
endmodule

// File: doc/single_port_ram_be.md
SINGLE_PORT_RAM_BE -- requirements
Module: single_port_ram_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning address bus width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL derive the local constant BE_WIDTH = DATA_WIDTH/8, meaning one byte-enable bit per byte lane.
REQ-005 clk  input  1  Single clock; all logic is clocked on the rising edge.
REQ-006 rst_n  input  1  Reset; synchronous to clk and active-low.
REQ-007 cs  input  1  Chip select; when high, an access request is present.
REQ-008 we  input  1  Access type: 1 = write, 0 = read; only meaningful while cs=1.
REQ-009 addr  input  ADDR_WIDTH  Word address.
REQ-010 wdata  input  DATA_WIDTH  Write data.
REQ-011 be  input  BE_WIDTH  Byte enables; be[i] selects wdata[8i+7:8i].
REQ-012 rdata  output  DATA_WIDTH  Read data; driven at all times, never high-impedance.
REQ-013 rvalid  output  1  One-cycle pulse marking that rdata is valid.
REQ-014 ready  output  1  High when accesses are accepted, i.e. the clear sweep has finished.
REQ-015 err  output  1  One-cycle pulse on an accepted access with addr >= DEPTH.

Function
REQ-016 SHALL implement a two-state FSM with states INIT and RUN.
REQ-017 INIT SHALL write zero to word init_cnt on every cycle, starting at init_cnt=0 and incrementing by one.
REQ-018 INIT SHALL transition to RUN on the cycle after the write to word DEPTH-1, so the clear takes exactly DEPTH cycles.
REQ-019 ready SHALL be 0 in INIT and 1 in RUN.
REQ-020 An access SHALL be accepted only when cs=1 and ready=1 on the same rising edge; cs during INIT SHALL be ignored, with no write, no rvalid and no err.
REQ-021 An accepted write with addr < DEPTH SHALL update, at that edge, only the byte lanes whose be bit is 1; all other lanes SHALL be kept.
REQ-022 An accepted write with be=0 SHALL leave memory unchanged and SHALL raise no err.
REQ-023 An accepted read with addr < DEPTH SHALL present mem[addr] on rdata with rvalid=1 in the cycle after acceptance (latency 1).
REQ-024 rdata SHALL hold its last value when rvalid=0.
REQ-025 Back-to-back reads on consecutive cycles SHALL produce consecutive rvalid pulses, one per read, in request order.
REQ-026 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-027 An accepted access with addr >= DEPTH SHALL not modify memory and SHALL pulse err in the cycle after acceptance.
REQ-028 An accepted read with addr >= DEPTH SHALL additionally return rdata=0 with rvalid=1 in that same cycle.
REQ-029 An accepted write SHALL never assert rvalid.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL load: state INIT, init_cnt=0, ready=0, rvalid=0, err=0, rdata=0, and any pipeline register = 0.
REQ-031 Reset asserted mid-sweep or mid-operation SHALL restart the clear from word 0 and SHALL discard any in-flight read.
REQ-032 Memory contents are undefined only until the clear sweep completes.

Configuration
REQ-033 Macro RAM_OUT_REG_EN, when defined, SHALL add an output register stage.
REQ-034 With RAM_OUT_REG_EN defined, read latency SHALL be 2 cycles, and rvalid, rdata and err SHALL be delayed together by one cycle.
REQ-035 With RAM_OUT_REG_EN not defined, read latency SHALL be 1 cycle, per REQ-023 and REQ-027.

Verification
REQ-036 Release reset, DEPTH=16 -> ready=0 for 16 cycles, then ready=1; a read of every address returns 0.
REQ-037 Write addr=3, wdata=0xAABBCCDD, be=4'b1111; then write addr=3, wdata=0x11223344, be=4'b0101 -> a read of addr 3 returns 0xAA22CC44 with rvalid 1 cycle after accept (2 cycles with RAM_OUT_REG_EN).
REQ-038 Reads of addr 1, 2, 3 on consecutive cycles after writes of 0x1, 0x2, 0x3 -> three consecutive rvalid pulses carrying 0x1, 0x2, 0x3.
REQ-039 With ADDR_WIDTH=5, DEPTH=20: write addr=25 followed by read addr=25 -> err pulses twice, the read returns rdata=0 with rvalid=1, and memory is unchanged.
REQ-040 Hold cs=1, we=1 during INIT; then assert rst_n=0 at sweep cycle 7 -> no writes occur, ready stays 0, and the sweep restarts with a full 16 cycles of ready=0.
